// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/release/short/long/repeat events.
// Auto-repeat while held after a long press is compiled in only when AUTO_REPEAT_EN is defined.
module button_event_gen #(
  parameter int CNT_W        = 24,
  parameter int LONG_DELAY   = 12_500_000,
  parameter int REPEAT_DELAY = 2_500_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  if (LONG_DELAY < 2 || REPEAT_DELAY < 2) begin : g_bad_delay
    $error("button_event_gen: LONG_DELAY and REPEAT_DELAY must be >= 2");
  end
  if ((64'd1 << CNT_W) <= 64'(LONG_DELAY) || (64'd1 << CNT_W) <= 64'(REPEAT_DELAY)) begin : g_bad_cnt_w
    $error("button_event_gen: CNT_W too narrow for the configured delays");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_DELAY - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

  state_t           state;
  logic             prev;
  logic [CNT_W-1:0] count;
  logic             rise, fall;

  assign rise = clean & ~prev;
  assign fall = ~clean & prev;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_DELAY - 1);
  logic repeat_q;
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      prev          <= 1'b0;
      count         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_q      <= 1'b0;
`endif
    end else begin
      prev          <= clean;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          count <= '0;
          if (rise) begin
            press_pulse <= 1'b1;
            held        <= 1'b1;
            state       <= PRESSED;
          end
        end
        PRESSED: begin
          // a release landing on the long-press edge still counts as a short click
          if (fall) begin
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            held          <= 1'b0;
            count         <= '0;
            state         <= IDLE;
          end else if (count == LONG_LAST) begin
            long_pulse <= 1'b1;
            count      <= '0;
            state      <= LONG_HELD;
          end else begin
            count <= count + 1'b1;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            count         <= '0;
            state         <= IDLE;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (count == REPEAT_LAST) begin
              repeat_q <= 1'b1;
              count    <= '0;
            end else begin
              count <= count + 1'b1;
            end
`else
            count <= '0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule
